// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: rx FSM states,
// scan-code prefix bytes, the FIFO entry layout and the parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         ENTRY_W        = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } fifo_entry_t;

    // PS/2 uses odd parity over data plus parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; a write while
// full is accepted only when a read happens in the same cycle, otherwise flagged on drop_o.
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_s, full_s, pop_s, push_s;

    // Handshake qualification and occupancy update
    always_comb begin
        empty_s = (count_q == {CW{1'b0}});
        full_s  = (count_q == CW'(DEPTH));
        pop_s   = rd_ready_i & ~empty_s;
        push_s  = wr_valid_i & (~full_s | pop_s);
        drop_o  = wr_valid_i & full_s & ~pop_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers (wrap naturally at power-of-two depth) and count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rd_valid_o = ~empty_s;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, 11-bit deframer with watchdog, output FIFO.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into the ext/brk entry flags.
module ps2_keyboard_rx_fifo
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2clk,
    input  logic                          ps2data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_code,
    output logic                          out_brk,
    output logic                          out_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow
);
    localparam int                WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   fall_s, bit_s;
    rx_state_e              state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   timeout_s, parity_fail_s, frame_fail_s, byte_done_s, abort_s;
    logic                   push_q, push_d;
    fifo_entry_t            push_entry_q, push_entry_d, head_s;
    logic                   parity_err_q, frame_err_q, timeout_err_q, overflow_q, drop_s;

    // Input synchronisers; idle PS/2 lines are high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2data};
        end
    end

    assign fall_s = ~clk_sync_q[SYNC_STAGES-2] & clk_sync_q[SYNC_STAGES-1];
    assign bit_s  = data_sync_q[SYNC_STAGES-1];

    // Deframer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            wd_q      <= {WD_W{1'b0}};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wd_q      <= wd_d;
        end
    end

    // Deframer next state; a falling edge outranks a simultaneous watchdog expiry
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if ((state_q == IDLE) || fall_s) begin
            wd_d = {WD_W{1'b0}};
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
        timeout_s = (state_q != IDLE) && !fall_s && (wd_q == WD_LAST);
        case (state_q)
            IDLE: begin
                if (fall_s && !bit_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (fall_s) begin
                    shift_d   = {bit_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end else if (timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (fall_s) begin
                    state_d = odd_parity_ok(shift_q, bit_s) ? STOP : IDLE;
                end else if (timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (fall_s || timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Deframer outputs: frame events for this cycle
    always_comb begin
        parity_fail_s = (state_q == PARITY) && fall_s && !odd_parity_ok(shift_q, bit_s);
        frame_fail_s  = (state_q == STOP) && fall_s && !bit_s;
        byte_done_s   = (state_q == STOP) && fall_s && bit_s;
        abort_s       = parity_fail_s | frame_fail_s | timeout_s;
    end

`ifdef PS2_PREFIX_DECODE_EN
    logic ext_q, ext_d, brk_q, brk_d;

    // Prefix bytes only latch flags; the next ordinary byte carries and clears them
    always_comb begin
        ext_d        = ext_q;
        brk_d        = brk_q;
        push_d       = 1'b0;
        push_entry_d = push_entry_q;
        if (abort_s) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_done_s) begin
            if (shift_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                push_d       = 1'b1;
                push_entry_d = '{ext: ext_q, brk: brk_q, code: shift_q};
                ext_d        = 1'b0;
                brk_d        = 1'b0;
            end
        end else begin
            push_d = 1'b0;
        end
    end

    // Prefix flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end
`else
    // Raw mode: every completed byte is queued with clear prefix flags
    always_comb begin
        push_d       = byte_done_s;
        push_entry_d = push_entry_q;
        if (byte_done_s) begin
            push_entry_d = '{ext: 1'b0, brk: 1'b0, code: shift_q};
        end else begin
            push_entry_d = push_entry_q;
        end
    end
`endif

    // Push request and error pulses are registered one cycle after the edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_q        <= 1'b0;
            push_entry_q  <= '0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            push_q        <= push_d;
            push_entry_q  <= push_entry_d;
            parity_err_q  <= parity_fail_s;
            frame_err_q   <= frame_fail_s;
            timeout_err_q <= timeout_s;
            overflow_q    <= overflow_q | drop_s;
        end
    end

    ps2_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (push_q),
        .wr_data_i  (push_entry_q),
        .rd_ready_i (out_ready),
        .rd_valid_o (out_valid),
        .rd_data_o  (head_s),
        .count_o    (fifo_count),
        .drop_o     (drop_s)
    );

    // Without prefix decode the stored ext/brk bits are always zero
    assign out_code    = head_s.code;
    assign out_brk     = head_s.brk;
    assign out_ext     = head_s.ext;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// Scoreboard bench for ps2_keyboard_rx_fifo: expected entries are queued as frames
// are sent and compared as the FIFO delivers them; error pulses are counted.
module tb_ps2_keyboard_rx_fifo;
    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HALF  = 15;

    logic       clk = 1'b0;
    logic       reset, ps2clk, ps2data, out_ready;
    logic       out_valid, out_brk, out_ext;
    logic [7:0] out_code;
    logic [3:0] fifo_count;
    logic       parity_err, frame_err, timeout_err, overflow;

    int         n_checks = 0;
    int         n_errors = 0;
    int         p_cnt = 0;
    int         f_cnt = 0;
    int         t_cnt = 0;
    logic [9:0] exp_q[$];

    ps2_keyboard_rx_fifo #(
        .SYNC_STAGES    (3),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2clk      (ps2clk),
        .ps2data     (ps2data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_brk     (out_brk),
        .out_ext     (out_ext),
        .fifo_count  (fifo_count),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: count error pulses and score delivered entries
    always @(negedge clk) begin
        if (!reset) begin
            if (parity_err)  p_cnt++;
            if (frame_err)   f_cnt++;
            if (timeout_err) t_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_entry", {22'd0, out_ext, out_brk, out_code}, 32'hFFFF_FFFF);
                end else begin
                    check("entry", {22'd0, out_ext, out_brk, out_code}, {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2data = b;
        wait_cycles(HALF);
        ps2clk = 1'b0;
        wait_cycles(HALF);
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(stop);
        ps2data = 1'b1;
        wait_cycles(40);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        ps2clk    = 1'b1;
        ps2data   = 1'b1;
        out_ready = 1'b1;
        wait_cycles(5);
        @(negedge clk);
        check("rst_valid",    {31'd0, out_valid}, 32'd0);
        check("rst_count",    {28'd0, fifo_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_errs",     {29'd0, parity_err, frame_err, timeout_err}, 32'd0);
        check("rst_head",     {22'd0, out_ext, out_brk, out_code}, 32'd0);
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(5);

        // Good frame 0x1C
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_drain("drain_1c");
        check("good_no_errs", p_cnt + f_cnt + t_cnt, 32'd0);

        // Bad parity
        send_frame(8'h1C, 1'b1, 1'b1);
        check("parity_pulse", p_cnt, 32'd1);
        check("parity_count", {28'd0, fifo_count}, 32'd0);

        // Stop bit 0, then a good 0x32
        send_frame(8'h1C, 1'b0, 1'b0);
        check("frame_pulse", f_cnt, 32'd1);
        exp_q.push_back({2'b00, 8'h32});
        send_frame(8'h32, 1'b0, 1'b1);
        wait_drain("drain_32");
        check("frame_count", {28'd0, fifo_count}, 32'd0);

        // Partial frame, watchdog expiry, then recovery
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2data = 1'b1;
        wait_cycles(TMO + 20);
        check("timeout_pulse", t_cnt, 32'd1);
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_drain("drain_after_tmo");

        // E0 F0 75
`ifdef PS2_PREFIX_DECODE_EN
        exp_q.push_back({2'b11, 8'h75});
`else
        exp_q.push_back({2'b00, 8'hE0});
        exp_q.push_back({2'b00, 8'hF0});
        exp_q.push_back({2'b00, 8'h75});
`endif
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        wait_drain("drain_prefix");

        // Overflow: DEPTH+1 bytes with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) exp_q.push_back({2'b00, 8'h10 + 8'(i)});
            send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
        end
        check("full_count",  {28'd0, fifo_count}, DEPTH);
        check("full_valid",  {31'd0, out_valid}, 32'd1);
        check("overflow_set", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        wait_drain("drain_full");
        check("empty_count", {28'd0, fifo_count}, 32'd0);
        check("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Reset mid-frame: partial frame dropped, overflow cleared, no pulses
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(5);
        check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        check("mid_rst_count", {28'd0, fifo_count}, 32'd0);
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_drain("drain_after_rst");
        check("final_errs", p_cnt * 100 + f_cnt * 10 + t_cnt, 32'd111);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
